// File: rtl/umidade_dht_reader_pkg.sv
// Shared types and constants for the DHT-style humidity reader.
package umni_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RELEASE,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } state_e;

    localparam int HUMIDITY_MAX = 100;
    localparam int FRAME_BITS   = 40;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/umidade_dht_reader.sv
// Single-wire DHT11-style humidity reader: start pulse, 40-bit frame capture,
// checksum verification and clamped integer humidity output.
module umidade_dht_reader
    import umni_pkg::*;
#(
    parameter int CYC_PER_US       = 50,
    parameter int START_LOW_US     = 18000,
    parameter int BIT_THRESH_US    = 50,
    parameter int TIMEOUT_US       = 200,
    parameter int SAMPLE_PERIOD_US = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_in,
    output logic       data_oe,
    output logic [6:0] humidity,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam int SAMPLE_CYC = SAMPLE_PERIOD_US * CYC_PER_US;
    localparam int START_CYC  = START_LOW_US * CYC_PER_US;
    localparam int THRESH_CYC = BIT_THRESH_US * CYC_PER_US;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_PER_US;
    localparam int CNT_W = $clog2(max_of3(START_CYC, SAMPLE_CYC, TIMEOUT_CYC + 1) + 1);

    logic line_sync;
    logic line_prev_q;
    logic line_rise;
    logic line_fall;

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [6:0]  humidity_q, humidity_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        data_oe_q, data_oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  checksum;
    logic        timed_out;

    // Idle line is pulled high, so the synchroniser resets high to avoid a false edge.
    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (data_in),
        .q    (line_sync)
    );

    assign line_rise = line_sync & ~line_prev_q;
    assign line_fall = ~line_sync & line_prev_q;
    assign timed_out = (cnt_q > CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d    = state_q;
        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        humidity_d = humidity_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        checksum   = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

        unique case (state_q)
            IDLE: begin
                if (cnt_q >= CNT_W'(SAMPLE_CYC - 1)) state_d = START;
            end
            START: begin
                if (cnt_q >= CNT_W'(START_CYC - 1)) state_d = RELEASE;
            end
            RELEASE: begin
                if (line_fall) state_d = RESP_LOW;
                else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            RESP_LOW: begin
                if (line_rise) state_d = RESP_HIGH;
                else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            RESP_HIGH: begin
                if (line_fall) begin
                    state_d   = BIT_LOW;
                    bit_cnt_d = '0;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            BIT_LOW: begin
                if (line_rise) state_d = BIT_HIGH;
                else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            // The counter holds the high time since entering this state.
            BIT_HIGH: begin
                if (line_fall) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], (cnt_q > CNT_W'(THRESH_CYC))};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? CHECK : BIT_LOW;
                end else if (timed_out) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
            end
            CHECK: begin
                if (checksum == shift_q[7:0]) begin
                    humidity_d = (shift_q[39:32] > 8'(HUMIDITY_MAX)) ?
                                 7'(HUMIDITY_MAX) : shift_q[38:32];
                    valid_d    = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        data_oe_d = (state_d == START);
        busy_d    = (state_d != IDLE);
    end

    // Counter is preloaded as expired so the first start pulse follows reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_W'(SAMPLE_CYC - 1);
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            humidity_q  <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            line_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            humidity_q  <= humidity_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            line_prev_q <= line_sync;
        end
    end

    assign data_oe  = data_oe_q;
    assign humidity = humidity_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_umidade_dht_reader.sv
// Directed bench for umidade_dht_reader with a cycle-level open-drain sensor model.
module tb_umidade_dht_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sensor_low = 1'b0;
    logic       data_in;
    logic       data_oe;
    logic [6:0] humidity;
    logic       valid;
    logic       error;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    int both_cnt  = 0;

    localparam logic [39:0] FRAME_55    = 40'h37_00_18_00_4F;
    localparam logic [39:0] FRAME_120   = 40'h78_00_14_00_8C;
    localparam logic [39:0] FRAME_BAD   = 40'h37_00_18_00_50;
    localparam logic [39:0] FRAME_42    = 40'h2A_00_00_00_2A;

    always #5 clock = ~clock;

    assign data_in = ~(data_oe | sensor_low);

    umidade_dht_reader #(
        .CYC_PER_US      (1),
        .START_LOW_US    (20),
        .BIT_THRESH_US   (50),
        .TIMEOUT_US      (200),
        .SAMPLE_PERIOD_US(500)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .data_oe (data_oe),
        .humidity(humidity),
        .valid   (valid),
        .error   (error),
        .busy    (busy)
    );

    always @(negedge clock) begin
        if (!reset) begin
            if (valid) valid_cnt <= valid_cnt + 1;
            if (error) error_cnt <= error_cnt + 1;
            if (valid && error) both_cnt <= both_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives the response and 40 bits; stops early inside the high phase of abort_bit.
    task automatic send_frame(input logic [39:0] frame, input int abort_bit);
        repeat (30) @(negedge clock);
        sensor_low = 1'b1;
        repeat (80) @(negedge clock);
        sensor_low = 1'b0;
        repeat (80) @(negedge clock);
        for (int i = 0; i < 40; i++) begin
            sensor_low = 1'b1;
            repeat (50) @(negedge clock);
            sensor_low = 1'b0;
            if (i == abort_bit) begin
                repeat (10) @(negedge clock);
                return;
            end
            repeat (frame[39-i] ? 70 : 27) @(negedge clock);
        end
        sensor_low = 1'b1;
    endtask

    task automatic receive(input logic [39:0] frame, output int lat,
                           output int vdiff, output int ediff);
        int v0;
        int e0;
        v0  = valid_cnt;
        e0  = error_cnt;
        lat = -1;
        send_frame(frame, -1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if ((valid || error) && lat < 0) lat = k;
        end
        repeat (42) @(negedge clock);
        sensor_low = 1'b0;
        repeat (5) @(negedge clock);
        vdiff = valid_cnt - v0;
        ediff = error_cnt - e0;
    endtask

    task automatic wait_release();
        int n;
        n = 0;
        while (data_oe !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (data_oe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_timeout: data_oe=%b expected 1 within 2000 cycles", data_oe);
        end
        n = 0;
        while (data_oe !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (data_oe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_timeout: data_oe=%b expected 0 within 100 cycles", data_oe);
        end
    endtask

    task automatic test_reset();
        int first_hi;
        int hi_cnt;
        int v_seen;
        logic busy_at_start;
        sensor_low = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (data_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_oe: got %b expected 0", data_oe); end
        checks++; if (humidity !== 7'd0) begin failures++; $display("[TB] FAIL reset_humidity: got %0d expected 0", humidity); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        first_hi = -1;
        hi_cnt = 0;
        v_seen = 0;
        busy_at_start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (data_oe === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            if (i == 1) busy_at_start = busy;
            if (valid !== 1'b0 || humidity !== 7'd0) v_seen++;
        end
        checks++; if (first_hi != 1) begin failures++; $display("[TB] FAIL start_delay: got %0d expected 1", first_hi); end
        checks++; if (hi_cnt != 20) begin failures++; $display("[TB] FAIL start_width: got %0d expected 20", hi_cnt); end
        checks++; if (busy_at_start !== 1'b1) begin failures++; $display("[TB] FAIL start_busy: got %b expected 1", busy_at_start); end
        checks++; if (v_seen != 0) begin failures++; $display("[TB] FAIL start_quiet: got %0d expected 0", v_seen); end
    endtask

    task automatic test_good_frame();
        int lat, vd, ed;
        receive(FRAME_55, lat, vd, ed);
        checks++; if (vd != 1) begin failures++; $display("[TB] FAIL good_valid_count: got %0d expected 1", vd); end
        checks++; if (ed != 0) begin failures++; $display("[TB] FAIL good_error_count: got %0d expected 0", ed); end
        checks++; if (lat != 4) begin failures++; $display("[TB] FAIL good_latency: got %0d expected 4", lat); end
        checks++; if (humidity !== 7'd55) begin failures++; $display("[TB] FAIL good_humidity: got %0d expected 55", humidity); end
    endtask

    task automatic test_clamp();
        int lat, vd, ed;
        wait_release();
        receive(FRAME_120, lat, vd, ed);
        checks++; if (vd != 1) begin failures++; $display("[TB] FAIL clamp_valid_count: got %0d expected 1", vd); end
        checks++; if (ed != 0) begin failures++; $display("[TB] FAIL clamp_error_count: got %0d expected 0", ed); end
        checks++; if (humidity !== 7'd100) begin failures++; $display("[TB] FAIL clamp_humidity: got %0d expected 100", humidity); end
    endtask

    task automatic test_bad_checksum();
        int lat, vd, ed;
        wait_release();
        receive(FRAME_55, lat, vd, ed);
        checks++; if (humidity !== 7'd55) begin failures++; $display("[TB] FAIL pre_bad_humidity: got %0d expected 55", humidity); end
        wait_release();
        receive(FRAME_BAD, lat, vd, ed);
        checks++; if (ed != 1) begin failures++; $display("[TB] FAIL bad_error_count: got %0d expected 1", ed); end
        checks++; if (vd != 0) begin failures++; $display("[TB] FAIL bad_valid_count: got %0d expected 0", vd); end
        checks++; if (lat != 4) begin failures++; $display("[TB] FAIL bad_latency: got %0d expected 4", lat); end
        checks++; if (humidity !== 7'd55) begin failures++; $display("[TB] FAIL bad_humidity_held: got %0d expected 55", humidity); end
    endtask

    task automatic test_no_response();
        int t_err;
        int t_start;
        wait_release();
        t_err = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clock);
            if (error === 1'b1) begin
                t_err = n;
                break;
            end
        end
        checks++; if (t_err != 202) begin failures++; $display("[TB] FAIL timeout_delay: got %0d expected 202", t_err); end
        t_start = -1;
        for (int m = 1; m <= 700; m++) begin
            @(negedge clock);
            if (data_oe === 1'b1) begin
                t_start = m;
                break;
            end
        end
        checks++; if (t_start != 500) begin failures++; $display("[TB] FAIL restart_period: got %0d expected 500", t_start); end
        checks++; if (humidity !== 7'd55) begin failures++; $display("[TB] FAIL timeout_humidity_held: got %0d expected 55", humidity); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, vd, ed;
        wait_release();
        send_frame(FRAME_42, 17);
        reset = 1'b1;
        #1;
        checks++; if (data_oe !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_oe: got %b expected 0", data_oe); end
        checks++; if (humidity !== 7'd0) begin failures++; $display("[TB] FAIL mid_reset_humidity: got %0d expected 0", humidity); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
        sensor_low = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (data_oe !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_restart: got %b expected 1", data_oe); end
        wait_release();
        receive(FRAME_42, lat, vd, ed);
        checks++; if (vd != 1) begin failures++; $display("[TB] FAIL post_reset_valid_count: got %0d expected 1", vd); end
        checks++; if (humidity !== 7'd42) begin failures++; $display("[TB] FAIL post_reset_humidity: got %0d expected 42", humidity); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_clamp();
        test_bad_checksum();
        test_no_response();
        test_reset_mid_frame();
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("[TB] FAIL valid_error_exclusive: got %0d overlaps expected 0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
